spike_history_recorder: RTL and testbench

Front-end for the STDP learning datapath. It samples pre- and post-synaptic spike vectors once per timestep tick and keeps them in per-neuron 16-deep history shift registers. These registers are the `PreShiftRegs`/`Post` words that the timing-difference priority encoder and the 16:1 pre mux consume. When new spikes arrive it requests a learning sweep, freezes the histories until the engine reports done, and buffers one tick that arrives during the sweep.

---
 rtl/spike_history_recorder.sv | 111 +++++++++++
 tb/tb_spike_history_recorder.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_history_recorder.sv
// rtl/spike_history_recorder.sv - per-neuron spike history shift registers with learning-sweep handshake
module spike_history_recorder #(
    parameter int NUM_PRE = 16,
    parameter int HIST    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick,
    input  logic [NUM_PRE-1:0]               pre_spike,
    input  logic                             post_spike,
    input  logic                             learn_done,
    output logic [0:NUM_PRE-1][HIST-1:0]     pre_hist,
    output logic [HIST-1:0]                  post_hist,
    output logic                             learn_req,
    output logic [15:0]                      ts_count,
    output logic                             overrun
);

    localparam int CW = NUM_PRE + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        REQ   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cap;
    logic [CW-1:0] pend;
    logic          pv;
    logic [CW-1:0] spikes_in;

    // Captured spike word layout: bit 0 is the post spike, bit i+1 is pre neuron i.
    assign spikes_in = {pre_spike, post_spike};

    // Sequencer: capture on tick, shift once, then hold histories frozen while a sweep runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pre_hist  <= '0;
            post_hist <= '0;
            cap       <= '0;
            pend      <= '0;
            pv        <= 1'b0;
            learn_req <= 1'b0;
            ts_count  <= '0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        cap   <= spikes_in;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    for (int i = 0; i < NUM_PRE; i++) begin
                        pre_hist[i] <= {pre_hist[i][HIST-2:0], cap[i+1]};
                    end
                    post_hist <= {post_hist[HIST-2:0], cap[0]};
                    ts_count  <= ts_count + 16'd1;
                    if (|cap) begin
                        state     <= REQ;
                        learn_req <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                    if (tick) begin
                        if (!pv) begin
                            pend <= spikes_in;
                            pv   <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (learn_done && pv) begin
                        // Drain the buffered timestep; a tick arriving now still sees pv set and is lost.
                        cap       <= pend;
                        pv        <= 1'b0;
                        learn_req <= 1'b0;
                        state     <= SHIFT;
                        if (tick) begin
                            overrun <= 1'b1;
                        end
                    end else if (learn_done && tick) begin
                        // Bypass: the coincident tick goes straight to cap without touching pend.
                        cap       <= spikes_in;
                        learn_req <= 1'b0;
                        state     <= SHIFT;
                    end else if (learn_done) begin
                        learn_req <= 1'b0;
                        state     <= IDLE;
                    end else if (tick) begin
                        if (!pv) begin
                            pend <= spikes_in;
                            pv   <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_history_recorder.sv
// tb/tb_spike_history_recorder.sv - randomized self-checking bench for spike_history_recorder
module tb_spike_history_recorder;

    logic              clk;
    logic              rst;
    logic              tick;
    logic [15:0]       pre_spike;
    logic              post_spike;
    logic              learn_done;
    logic [0:15][15:0] pre_hist;
    logic [15:0]       post_hist;
    logic              learn_req;
    logic [15:0]       ts_count;
    logic              overrun;

    int total;
    int bad;

    // Model: list of timesteps actually applied, oldest first; bit 0 = post, bit i+1 = pre[i].
    logic [16:0] applied[$];
    logic [15:0] mcount;

    spike_history_recorder #(.NUM_PRE(16), .HIST(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .learn_done (learn_done),
        .pre_hist   (pre_hist),
        .post_hist  (post_hist),
        .learn_req  (learn_req),
        .ts_count   (ts_count),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_word(input int b);
        logic [15:0] w;
        int n;
        w = '0;
        n = applied.size();
        for (int k = 0; k < 16 && k < n; k++) w[k] = applied[n-1-k][b];
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input logic [16:0] v);
        applied.push_back(v);
        mcount = mcount + 16'd1;
    endtask

    task automatic model_clear();
        applied.delete();
        mcount = '0;
    endtask

    task automatic drive_tick(input logic [16:0] v);
        tick       = 1'b1;
        pre_spike  = v[16:1];
        post_spike = v[0];
    endtask

    task automatic drive_idle();
        tick       = 1'b0;
        pre_spike  = '0;
        post_spike = 1'b0;
        learn_done = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick       = 1'($urandom_range(0, 1));
            pre_spike  = 16'($urandom);
            post_spike = 1'($urandom_range(0, 1));
            learn_done = 1'($urandom_range(0, 1));
            cyc();
            total++;
            if ({pre_hist, post_hist, learn_req, ts_count, overrun} !== '0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got post=%h req=%b cnt=%h ovr=%b exp all zero", c, post_hist, learn_req, ts_count, overrun);
            end
        end
        rst = 1'b0;
        drive_idle();
        model_clear();
        cyc();
        total++;
        if ({pre_hist, post_hist, learn_req, ts_count, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_after got post=%h req=%b cnt=%h ovr=%b exp all zero", post_hist, learn_req, ts_count, overrun);
        end
    endtask

    task automatic test_post_train();
        for (int t = 0; t < 3; t++) begin
            drive_tick(17'h00001);
            cyc();
            drive_idle();
            total++;
            if (learn_req !== 1'b0) begin
                bad++;
                $display("FAIL train_req_early t=%0d got %b exp 0", t, learn_req);
            end
            cyc();
            model_apply(17'h00001);
            total++;
            if (learn_req !== 1'b1) begin
                bad++;
                $display("FAIL train_req_rise t=%0d got %b exp 1", t, learn_req);
            end
            cyc();
            learn_done = 1'b1;
            cyc();
            learn_done = 1'b0;
            total++;
            if (learn_req !== 1'b0) begin
                bad++;
                $display("FAIL train_req_fall t=%0d got %b exp 0", t, learn_req);
            end
        end
        total++;
        if (post_hist !== 16'h0007 || post_hist !== exp_word(0)) begin
            bad++;
            $display("FAIL train_post_hist got %h exp 0007", post_hist);
        end
        total++;
        if (ts_count !== 16'd3 || ts_count !== mcount) begin
            bad++;
            $display("FAIL train_ts_count got %0d exp 3", ts_count);
        end
    endtask

    task automatic test_pre_oldest();
        logic [16:0] v;
        int rises;
        logic prev;
        do_reset();
        v = {16'($urandom), 1'($urandom_range(0, 1))};
        v[6] = 1'b1;
        drive_tick(v);
        cyc();
        drive_idle();
        cyc();
        model_apply(v);
        rises = (learn_req === 1'b1) ? 1 : 0;
        learn_done = 1'b1;
        cyc();
        learn_done = 1'b0;
        prev = learn_req;
        for (int t = 0; t < 15; t++) begin
            drive_tick('0);
            cyc();
            drive_idle();
            if (learn_req === 1'b1 && prev !== 1'b1) rises++;
            prev = learn_req;
            cyc();
            model_apply('0);
            if (learn_req === 1'b1 && prev !== 1'b1) rises++;
            prev = learn_req;
        end
        total++;
        if (rises !== 1) begin
            bad++;
            $display("FAIL oldest_req_count got %0d exp 1", rises);
        end
        total++;
        if (pre_hist[5] !== 16'h8000) begin
            bad++;
            $display("FAIL oldest_pre5 got %h exp 8000", pre_hist[5]);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (pre_hist[i] !== exp_word(i + 1)) begin
                bad++;
                $display("FAIL oldest_pre[%0d] got %h exp %h", i, pre_hist[i], exp_word(i + 1));
            end
        end
        drive_tick('0);
        cyc();
        drive_idle();
        cyc();
        model_apply('0);
        total++;
        if (pre_hist[5] !== 16'h0000) begin
            bad++;
            $display("FAIL oldest_pre5_gone got %h exp 0000", pre_hist[5]);
        end
        total++;
        if (ts_count !== mcount) begin
            bad++;
            $display("FAIL oldest_ts_count got %0d exp %0d", ts_count, mcount);
        end
    endtask

    task automatic test_pending_overrun();
        logic [16:0] x, a, b;
        do_reset();
        x = {16'($urandom), 1'b1};
        a = {16'($urandom), 1'b1};
        b = {16'($urandom), 1'($urandom_range(0, 1))};
        drive_tick(x);
        cyc();
        drive_idle();
        cyc();
        model_apply(x);
        drive_tick(a);
        cyc();
        drive_idle();
        cyc();
        drive_tick(b);
        cyc();
        drive_idle();
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL pend_overrun got %b exp 1", overrun);
        end
        total++;
        if (post_hist !== exp_word(0) || pre_hist[0] !== exp_word(1)) begin
            bad++;
            $display("FAIL pend_frozen got post=%h pre0=%h exp post=%h pre0=%h", post_hist, pre_hist[0], exp_word(0), exp_word(1));
        end
        cyc();
        learn_done = 1'b1;
        cyc();
        learn_done = 1'b0;
        total++;
        if (learn_req !== 1'b0 || ts_count !== 16'd1) begin
            bad++;
            $display("FAIL pend_gap got req=%b cnt=%0d exp req=0 cnt=1", learn_req, ts_count);
        end
        cyc();
        model_apply(a);
        total++;
        if (learn_req !== 1'b1 || ts_count !== mcount) begin
            bad++;
            $display("FAIL pend_apply got req=%b cnt=%0d exp req=1 cnt=%0d", learn_req, ts_count, mcount);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (pre_hist[i] !== exp_word(i + 1)) begin
                bad++;
                $display("FAIL pend_pre[%0d] got %h exp %h", i, pre_hist[i], exp_word(i + 1));
            end
        end
        learn_done = 1'b1;
        cyc();
        learn_done = 1'b0;
        cyc();
        cyc();
        total++;
        if (learn_req !== 1'b0 || ts_count !== mcount || overrun !== 1'b1 || post_hist !== exp_word(0)) begin
            bad++;
            $display("FAIL pend_drop got req=%b cnt=%0d ovr=%b post=%h exp req=0 cnt=%0d ovr=1 post=%h",
                     learn_req, ts_count, overrun, post_hist, mcount, exp_word(0));
        end
    endtask

    task automatic test_bypass();
        logic [16:0] x, y;
        do_reset();
        x = {16'($urandom), 1'b1};
        y = {16'($urandom), 1'b1};
        drive_tick(x);
        cyc();
        drive_idle();
        cyc();
        model_apply(x);
        drive_tick(y);
        learn_done = 1'b1;
        cyc();
        drive_idle();
        total++;
        if (learn_req !== 1'b0) begin
            bad++;
            $display("FAIL bypass_gap got %b exp 0", learn_req);
        end
        cyc();
        model_apply(y);
        total++;
        if (learn_req !== 1'b1 || ts_count !== mcount || overrun !== 1'b0) begin
            bad++;
            $display("FAIL bypass_shift got req=%b cnt=%0d ovr=%b exp req=1 cnt=%0d ovr=0", learn_req, ts_count, overrun, mcount);
        end
        total++;
        if (post_hist !== exp_word(0) || pre_hist[15] !== exp_word(16)) begin
            bad++;
            $display("FAIL bypass_hist got post=%h pre15=%h exp post=%h pre15=%h", post_hist, pre_hist[15], exp_word(0), exp_word(16));
        end
        learn_done = 1'b1;
        cyc();
        learn_done = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_req();
        logic [16:0] x;
        do_reset();
        x = {16'($urandom), 1'b1};
        drive_tick(x);
        cyc();
        drive_idle();
        cyc();
        drive_tick({16'($urandom), 1'b1});
        cyc();
        rst = 1'b1;
        learn_done = 1'b1;
        cyc();
        rst = 1'b0;
        drive_idle();
        model_clear();
        total++;
        if ({pre_hist, post_hist, learn_req, ts_count, overrun} !== '0) begin
            bad++;
            $display("FAIL midreq_reset got post=%h req=%b cnt=%h ovr=%b exp all zero", post_hist, learn_req, ts_count, overrun);
        end
        learn_done = 1'b1;
        cyc();
        learn_done = 1'b0;
        cyc();
        cyc();
        total++;
        if ({pre_hist, post_hist, learn_req, ts_count} !== '0) begin
            bad++;
            $display("FAIL midreq_stale_done got post=%h req=%b cnt=%h exp all zero", post_hist, learn_req, ts_count);
        end
        force dut.ts_count = 16'hFFFF;
        #2;
        release dut.ts_count;
        mcount = 16'hFFFF;
        drive_tick('0);
        cyc();
        drive_idle();
        cyc();
        model_apply('0);
        total++;
        if (ts_count !== 16'h0000 || ts_count !== mcount) begin
            bad++;
            $display("FAIL midreq_wrap got %h exp 0000", ts_count);
        end
        total++;
        if (learn_req !== 1'b0 || post_hist !== 16'h0000) begin
            bad++;
            $display("FAIL midreq_empty_tick got req=%b post=%h exp req=0 post=0000", learn_req, post_hist);
        end
    endtask

    task automatic test_random();
        logic [16:0] v, w;
        int pflag;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            v = {16'($urandom), 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 3) == 0) v = '0;
            drive_tick(v);
            cyc();
            drive_idle();
            cyc();
            model_apply(v);
            total++;
            if (learn_req !== (v != '0)) begin
                bad++;
                $display("FAIL rand_req it=%0d got %b exp %b", it, learn_req, (v != '0));
            end
            if (v != '0) begin
                pflag = int'($urandom_range(0, 1));
                w = '0;
                if (pflag != 0) begin
                    w = {16'($urandom), 1'($urandom_range(0, 1))};
                    if ($urandom_range(0, 2) == 0) w = '0;
                    drive_tick(w);
                    cyc();
                    drive_idle();
                end
                repeat ($urandom_range(0, 3)) cyc();
                learn_done = 1'b1;
                cyc();
                learn_done = 1'b0;
                if (pflag != 0) begin
                    cyc();
                    model_apply(w);
                    total++;
                    if (learn_req !== (w != '0)) begin
                        bad++;
                        $display("FAIL rand_pend_req it=%0d got %b exp %b", it, learn_req, (w != '0));
                    end
                    if (w != '0) begin
                        learn_done = 1'b1;
                        cyc();
                        learn_done = 1'b0;
                    end
                end
            end
            total++;
            if (post_hist !== exp_word(0) || ts_count !== mcount || overrun !== 1'b0) begin
                bad++;
                $display("FAIL rand_state it=%0d got post=%h cnt=%0d ovr=%b exp post=%h cnt=%0d ovr=0",
                         it, post_hist, ts_count, overrun, exp_word(0), mcount);
            end
            for (int i = 0; i < 16; i++) begin
                total++;
                if (pre_hist[i] !== exp_word(i + 1)) begin
                    bad++;
                    $display("FAIL rand_pre[%0d] it=%0d got %h exp %h", i, it, pre_hist[i], exp_word(i + 1));
                end
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mcount = '0;
        rst    = 1'b1;
        drive_idle();
        test_reset();
        test_post_train();
        test_pre_oldest();
        test_pending_overrun();
        test_bypass();
        test_reset_mid_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
